// File: rtl/dcache_dm.sv
// -----------------------------------------------------------------------------
// dcache_dm -- direct-mapped, write-through, no-write-allocate data cache
//
// Build option: define DCACHE_STATS_EN to add the hit_cnt / miss_cnt load
// statistics outputs. Without it the block has no statistics ports.
//
// Address split: [31 : OFF_W+IDX_W] tag | [OFF_W+IDX_W-1 : OFF_W] index |
//                [OFF_W-1 : 0] byte offset within the line.
//
// Ports
//   clk          sole clock, all state updates on posedge
//   rst          synchronous reset, active low
//   pipeline_en  a request is only accepted while high
//   ren/wen      load / store request (store wins when both are high)
//   addr         byte address of the request
//   rwidth       load width in bytes (1, 2, anything else = 4)
//   rsign        1 = sign-extend narrow loads, 0 = zero-extend
//   rdata        registered load result
//   wwidth       store width in bytes (1, 2, anything else = 4)
//   wdata        store data, right-aligned
//   valid        1 = ready for a request, 0 = busy (pipeline must stall)
//   mem_*        single-beat memory port; mem_req/mem_addr held until mem_ack,
//                mem_rdata sampled in the mem_ack cycle
//   hit_cnt      (DCACHE_STATS_EN) accepted loads that hit
//   miss_cnt     (DCACHE_STATS_EN) accepted loads that missed
// -----------------------------------------------------------------------------
module dcache_dm #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_en,
    input  logic        ren,
    input  logic [31:0] addr,
    input  logic [2:0]  rwidth,
    input  logic        rsign,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [2:0]  wwidth,
    input  logic [31:0] wdata,
    output logic        valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    // Index and word-in-line bits are adjacent in the address, so together
    // they form the word address into one flat data array.
    localparam int WIX_W  = IDX_W + OFF_W - 2;
    localparam int DEPTH  = SETS * LINE_WORDS;
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Tag store and per-line valid bits
    logic [TAG_W-1:0] r_tag [SETS];
    logic [SETS-1:0]  r_line_valid;

    // Request captured at acceptance
    logic [31:0]       r_addr;
    logic [2:0]        r_rwidth;
    logic              r_rsign;
    logic [31:0]       r_wlane;
    logic [3:0]        r_wstrb;
    logic [BEAT_W-1:0] r_beat;
    logic [31:0]       r_fill_word;
    logic [31:0]       r_rdata;

    // Combinational decode of the incoming request
    logic [IDX_W-1:0] w_req_set;
    logic [TAG_W-1:0] w_req_tag;
    logic [WIX_W-1:0] w_req_wix;
    logic             w_hit;
    logic             w_accept;
    logic             w_load_accept;
    logic             w_store_accept;
    logic [31:0]      w_store_lane;
    logic [3:0]       w_store_strb;
    logic [31:0]      w_rd_word;

    // Refill bookkeeping
    logic [IDX_W-1:0] w_r_set;
    logic [TAG_W-1:0] w_r_tag;
    logic [31:0]      w_beat_addr;
    logic [WIX_W-1:0] w_fill_wix;
    logic             w_beat_ack;
    logic             w_last_beat;
    logic             w_beat_is_target;
    logic [31:0]      w_fill_word;
    logic             w_fill_we;
    logic             w_hit_we;

    // FSM outputs
    logic        w_valid;
    logic        w_mem_req;
    logic        w_mem_we;
    logic [31:0] w_mem_addr;
    logic [3:0]  w_mem_wstrb;

    // -------------------------------------------------------------------------
    // Lane extraction and extension for loads; any width other than 1 or 2 is
    // a full word and ignores the sign flag.
    // -------------------------------------------------------------------------
    function automatic logic [31:0] f_load(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  width,
                                           input logic        sign);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        v_byte = word[{off, 3'b000} +: 8];
        v_half = off[1] ? word[31:16] : word[15:0];
        case (width)
            3'd1:    v_res = {{24{sign & v_byte[7]}}, v_byte};
            3'd2:    v_res = {{16{sign & v_half[15]}}, v_half};
            default: v_res = word;
        endcase
        return v_res;
    endfunction

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign w_req_set      = addr[OFF_W +: IDX_W];
    assign w_req_tag      = addr[31 -: TAG_W];
    assign w_req_wix      = addr[2 +: WIX_W];
    assign w_hit          = r_line_valid[w_req_set] && (r_tag[w_req_set] == w_req_tag);
    assign w_accept       = (r_state == IDLE) && pipeline_en && (ren || wen);
    assign w_store_accept = w_accept && wen;
    assign w_load_accept  = w_accept && !wen;

    // Store data moved onto its byte lanes, with matching strobes
    always_comb begin
        w_store_lane = wdata;
        w_store_strb = 4'b1111;
        case (wwidth)
            3'd1: begin
                w_store_lane = {24'd0, wdata[7:0]} << {addr[1:0], 3'b000};
                w_store_strb = 4'b0001 << addr[1:0];
            end
            3'd2: begin
                w_store_lane = addr[1] ? {wdata[15:0], 16'd0} : {16'd0, wdata[15:0]};
                w_store_strb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_store_lane = wdata;
                w_store_strb = 4'b1111;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Refill addressing: beats walk the line from its base, one word each
    // -------------------------------------------------------------------------
    assign w_r_set          = r_addr[OFF_W +: IDX_W];
    assign w_r_tag          = r_addr[31 -: TAG_W];
    assign w_beat_addr      = {r_addr[31:OFF_W], {OFF_W{1'b0}}}
                            | {{(30 - BEAT_W){1'b0}}, r_beat, 2'b00};
    assign w_fill_wix       = w_beat_addr[2 +: WIX_W];
    assign w_beat_ack       = (r_state == REFILL) && mem_ack;
    assign w_last_beat      = (r_beat == BEAT_W'(LINE_WORDS - 1));
    assign w_beat_is_target = (w_beat_addr[31:2] == r_addr[31:2]);
    // The requested word may arrive on the final beat, in which case the
    // array has not been written yet; take it straight from the bus.
    assign w_fill_word      = w_beat_is_target ? mem_rdata : r_fill_word;

    // Array writes are suppressed while reset is asserted
    assign w_fill_we = rst && w_beat_ack;
    assign w_hit_we  = rst && w_store_accept && w_hit;

    // -------------------------------------------------------------------------
    // Data array, one byte-wide array per lane so stores write only strobed
    // bytes. Refill beats always write all four lanes.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (w_fill_we) begin
                    r_mem[w_fill_wix] <= mem_rdata[8*gi +: 8];
                end else if (w_hit_we && w_store_strb[gi]) begin
                    r_mem[w_req_wix] <= w_store_lane[8*gi +: 8];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_mem[w_req_wix];
        end
    endgenerate

    // Tag store has no reset: the valid bits alone qualify it
    always_ff @(posedge clk) begin
        if (w_fill_we && w_last_beat) begin
            r_tag[w_r_set] <= w_r_tag;
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and memory-port outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = {r_addr[31:2], 2'b00};
        w_mem_wstrb  = 4'b0000;
        case (r_state)
            IDLE: begin
                w_valid = 1'b1;
                if (w_store_accept) begin
                    w_state_next = WRITE;
                end else if (w_load_accept && !w_hit) begin
                    w_state_next = REFILL;
                end
            end
            REFILL: begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_beat_addr;
                if (mem_ack && w_last_beat) begin
                    w_state_next = IDLE;
                end
            end
            WRITE: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_wstrb = r_wstrb;
                if (mem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture, refill progress, line valid bits and load result
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_line_valid <= '0;
            r_addr       <= '0;
            r_rwidth     <= '0;
            r_rsign      <= 1'b0;
            r_wlane      <= '0;
            r_wstrb      <= '0;
            r_beat       <= '0;
            r_fill_word  <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= addr;
                r_rwidth <= rwidth;
                r_rsign  <= rsign;
                r_wlane  <= w_store_lane;
                r_wstrb  <= w_store_strb;
                r_beat   <= '0;
                if (w_load_accept) begin
                    if (w_hit) begin
                        r_rdata <= f_load(w_rd_word, addr[1:0], rwidth, rsign);
                    end else begin
                        // The line is about to be overwritten beat by beat
                        r_line_valid[w_req_set] <= 1'b0;
                    end
                end
            end

            if (w_beat_ack) begin
                r_beat <= r_beat + BEAT_W'(1);
                if (w_beat_is_target) begin
                    r_fill_word <= mem_rdata;
                end
                if (w_last_beat) begin
                    r_line_valid[w_r_set] <= 1'b1;
                    r_rdata <= f_load(w_fill_word, r_addr[1:0], r_rwidth, r_rsign);
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // -------------------------------------------------------------------------
    // Load statistics; stores are not counted, counters wrap naturally
    // -------------------------------------------------------------------------
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_load_accept) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign rdata     = r_rdata;
    assign valid     = w_valid;
    assign mem_req   = w_mem_req;
    assign mem_we    = w_mem_we;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = r_wlane;
    assign mem_wstrb = w_mem_wstrb;

endmodule

// File: tb/tb_dcache_dm.sv
module tb_dcache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipeline_en;
    logic        ren;
    logic [31:0] addr;
    logic [2:0]  rwidth;
    logic        rsign;
    logic [31:0] rdata;
    logic        wen;
    logic [2:0]  wwidth;
    logic [31:0] wdata;
    logic        valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit ok;

    logic [31:0] beat_addr [$];
    logic        beat_we   [$];
    logic [3:0]  beat_strb [$];
    logic [31:0] beat_wdata[$];
    int          wait_cnt;

    always #5 clk = ~clk;

    dcache_dm #(
        .SETS       (64),
        .LINE_WORDS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipeline_en (pipeline_en),
        .ren         (ren),
        .addr        (addr),
        .rwidth      (rwidth),
        .rsign       (rsign),
        .rdata       (rdata),
        .wen         (wen),
        .wwidth      (wwidth),
        .wdata       (wdata),
        .valid       (valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (mem_req) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr;
                    beat_addr.push_back(mem_addr);
                    beat_we.push_back(mem_we);
                    beat_strb.push_back(mem_wstrb);
                    beat_wdata.push_back(mem_wdata);
                    wait_cnt  = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("PASS %s: observed=0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        beat_addr.delete();
        beat_we.delete();
        beat_strb.delete();
        beat_wdata.delete();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] w, input logic s);
        ren    = 1'b1;
        wen    = 1'b0;
        addr   = a;
        rwidth = w;
        rsign  = s;
        tick();
        ren    = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d,
                            input logic also_ren);
        wen    = 1'b1;
        ren    = also_ren;
        addr   = a;
        wwidth = w;
        wdata  = d;
        rwidth = 3'd4;
        rsign  = 1'b0;
        tick();
        wen    = 1'b0;
        ren    = 1'b0;
    endtask

    task automatic wait_valid(output bit done);
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (valid) done = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        pipeline_en = 1'b1;
        ren         = 1'b0;
        wen         = 1'b0;
        addr        = 32'd0;
        rwidth      = 3'd4;
        rsign       = 1'b0;
        wwidth      = 3'd4;
        wdata       = 32'd0;

        tick();
        tick();
        check("rst_valid", valid, 1'b1);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        rst = 1'b1;
        tick();

        clear_log();
        do_load(32'h100, 3'd4, 1'b0);
        check("miss_valid_low", valid, 1'b0);
        check("miss_mem_req", mem_req, 1'b1);
        check("miss_first_addr", mem_addr, 32'h100);
        check("miss_wstrb", mem_wstrb, 4'b0000);
        wait_valid(ok);
        check("miss_done", ok, 1'b1);
        check("miss_beats", beat_addr.size(), 4);
        for (int i = 0; i < beat_addr.size() && i < 4; i++) begin
            check("miss_beat_addr", beat_addr[i], 32'h100 + 32'(4 * i));
            check("miss_beat_we", beat_we[i], 1'b0);
        end
        check("miss_rdata", rdata, 32'h100);
        check("miss_idle_req", mem_req, 1'b0);

        clear_log();
        do_load(32'h104, 3'd4, 1'b0);
        check("hit_rdata", rdata, 32'h104);
        check("hit_valid", valid, 1'b1);
        check("hit_mem_req", mem_req, 1'b0);
`ifdef DCACHE_STATS_EN
        check("stats_miss", miss_cnt, 32'd1);
        check("stats_hit", hit_cnt, 32'd1);
`endif

        clear_log();
        do_store(32'h105, 3'd1, 32'h80, 1'b0);
        check("sb_valid_low", valid, 1'b0);
        check("sb_mem_we", mem_we, 1'b1);
        check("sb_wstrb", mem_wstrb, 4'b0010);
        check("sb_wdata", mem_wdata, 32'h0000_8000);
        check("sb_addr", mem_addr, 32'h104);
        wait_valid(ok);
        check("sb_done", ok, 1'b1);
        check("sb_beats", beat_addr.size(), 1);

        clear_log();
        do_load(32'h105, 3'd1, 1'b1);
        check("lb_signed", rdata, 32'hFFFF_FF80);
        check("lb_signed_valid", valid, 1'b1);
        do_load(32'h105, 3'd1, 1'b0);
        check("lb_unsigned", rdata, 32'h0000_0080);
        do_load(32'h104, 3'd2, 1'b1);
        check("lh_signed", rdata, 32'hFFFF_8004);
        do_load(32'h104, 3'd3, 1'b1);
        check("lw_width3", rdata, 32'h0000_8004);
        check("narrow_no_beats", beat_addr.size(), 0);

        clear_log();
        do_store(32'h10B, 3'd2, 32'h0000_BEEF, 1'b0);
        check("sh_wstrb", mem_wstrb, 4'b1100);
        check("sh_wdata", mem_wdata, 32'hBEEF_0000);
        wait_valid(ok);
        check("sh_done", ok, 1'b1);
        do_load(32'h108, 3'd4, 1'b0);
        check("sh_readback", rdata, 32'hBEEF_0108);
        do_load(32'h10B, 3'd1, 1'b1);
        check("sh_byte3", rdata, 32'hFFFF_FFBE);

        clear_log();
        pipeline_en = 1'b0;
        do_load(32'h200, 3'd4, 1'b0);
        check("pe_valid", valid, 1'b1);
        check("pe_mem_req", mem_req, 1'b0);
        check("pe_rdata_held", rdata, 32'hFFFF_FFBE);
        pipeline_en = 1'b1;

        clear_log();
        do_store(32'h2000, 3'd4, 32'h1234_5678, 1'b0);
        wait_valid(ok);
        check("sw_miss_done", ok, 1'b1);
        check("sw_miss_beats", beat_addr.size(), 1);
        if (beat_addr.size() > 0) begin
            check("sw_miss_addr", beat_addr[0], 32'h2000);
            check("sw_miss_we", beat_we[0], 1'b1);
            check("sw_miss_strb", beat_strb[0], 4'b1111);
            check("sw_miss_wdata", beat_wdata[0], 32'h1234_5678);
        end
        clear_log();
        do_load(32'h2000, 3'd4, 1'b0);
        wait_valid(ok);
        check("noalloc_done", ok, 1'b1);
        check("noalloc_beats", beat_addr.size(), 4);
        check("noalloc_rdata", rdata, 32'h2000);

        clear_log();
        do_store(32'h100, 3'd4, 32'hA5A5_A5A5, 1'b1);
        check("both_mem_we", mem_we, 1'b1);
        wait_valid(ok);
        check("both_done", ok, 1'b1);
        check("both_beats", beat_addr.size(), 1);
        check("both_rdata_held", rdata, 32'h2000);
        clear_log();
        do_load(32'h100, 3'd4, 1'b0);
        check("both_readback", rdata, 32'hA5A5_A5A5);
        check("both_readback_hit", beat_addr.size(), 0);

        clear_log();
        do_load(32'h3004, 3'd4, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (beat_addr.size() == 2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("abort_two_beats", ok, 1'b1);
        rst = 1'b0;
        tick();
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_valid", valid, 1'b1);
        check("abort_rdata", rdata, 32'h0);
        rst = 1'b1;
        tick();

        clear_log();
        do_load(32'h3004, 3'd4, 1'b0);
        wait_valid(ok);
        check("refill_after_abort_done", ok, 1'b1);
        check("refill_after_abort_beats", beat_addr.size(), 4);
        if (beat_addr.size() > 0) begin
            check("refill_after_abort_base", beat_addr[0], 32'h3000);
        end
        check("refill_after_abort_rdata", rdata, 32'h3004);

        clear_log();
        do_load(32'h100, 3'd4, 1'b0);
        check("reinval_miss", valid, 1'b0);
        wait_valid(ok);
        check("reinval_done", ok, 1'b1);
        check("reinval_beats", beat_addr.size(), 4);
        check("reinval_rdata", rdata, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_dm.md
DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 SHALL have parameter SETS, default 64, number of lines (power of two, >=2).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, >=1).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, all state on posedge.
- rst  in  1  reset, synchronous, active-low.
- pipeline_en  in  1  pipeline advance; request accepted only when high.
- ren  in  1  load request.
- addr  in  32  byte address.
- rwidth  in  3  load width in bytes: 1, 2 or 4.
- rsign  in  1  0 = zero-extend, 1 = sign-extend.
- rdata  out  32  registered load result.
- wen  in  1  store request.
- wwidth  in  3  store width in bytes: 1, 2 or 4.
- wdata  in  32  store data, right-aligned.
- valid  out  1  0 = busy, pipeline must stall.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write beat.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  write data, lane-aligned.
- mem_wstrb  out  4  byte strobes.
- mem_ack  in  1  beat complete; mem_rdata valid same cycle.
- mem_rdata  in  32  read beat data.

Function
REQ-004 SHALL be direct-mapped: offset = log2(LINE_WORDS*4) bits, index = log2(SETS) bits, tag = remaining upper bits; one valid bit per line.
REQ-005 SHALL accept a request at a posedge with valid=1, pipeline_en=1 and (ren or wen); it SHALL capture addr, widths, rsign and wdata, and ignore inputs until valid returns to 1.
REQ-006 SHALL give wen priority when ren and wen are both high; the read is dropped.
REQ-007 SHALL use FSM states IDLE, REFILL, WRITE, reset state IDLE.
REQ-008 Read hit: rdata SHALL update at the accepting edge, latency 1, valid stays 1, FSM stays IDLE.
REQ-009 Read miss: at the accepting edge, valid SHALL go 0 and the FSM SHALL enter REFILL.
REQ-010 REFILL SHALL issue LINE_WORDS read beats from the line base, ascending, with mem_we=0 and mem_wstrb=0.
REQ-011 Each REFILL beat SHALL hold mem_req and mem_addr until mem_ack, and SHALL write mem_rdata into the line on mem_ack.
REQ-012 On the last-beat ack, the FSM SHALL set tag and valid, load rdata from the filled word, set valid=1 and return to IDLE; the next request is accepted one cycle later.
REQ-013 Stores SHALL be write-through, no-write-allocate.
REQ-014 At store acceptance, a hit SHALL update only the strobed bytes in the line; a miss SHALL leave the cache unchanged.
REQ-015 At store acceptance, valid SHALL go 0 and the FSM SHALL enter WRITE.
REQ-016 WRITE SHALL hold one beat (mem_we=1) until mem_ack, then set valid=1 and return to IDLE.
REQ-017 Lane selection: byte uses addr[1:0]; half uses addr[1] (addr[0] ignored); word ignores addr[1:0]; strobes 0001<<addr[1:0], 0011<<2*addr[1], 1111.
REQ-018 Loads SHALL extract the selected lane and zero- or sign-extend per rsign; width 4 ignores rsign.
REQ-019 Width values other than 1 or 2 SHALL be treated as 4.
REQ-020 Idle cycles (no accepted request) SHALL hold rdata and all cache state.
REQ-021 mem_req SHALL be 0 in IDLE.

Reset
REQ-022 While rst=0 at a posedge, the block SHALL set valid=1, rdata=0, mem_req=0, mem_we=0, FSM=IDLE and clear all line valid bits.
REQ-023 Reset during REFILL or WRITE SHALL abort the operation; the partly filled line SHALL stay invalid, and mem_req SHALL be 0 from the first reset edge.

Configuration
REQ-024 With DCACHE_STATS_EN defined, the block SHALL add 32-bit outputs hit_cnt and miss_cnt, counting accepted loads by outcome (stores not counted), wrapping at 2^32, and cleared by reset.
REQ-025 Without DCACHE_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-026 Reset, then ren at 0x100, width 4, with mem_ack after 2 cycles per beat and mem_rdata = address: expect valid=0 and beats at 0x100, 0x104, 0x108, 0x10C; then rdata=0x00000100 and valid=1.
REQ-027 Read 0x104 after REQ-026: expect hit, rdata=0x00000104 next edge, valid held 1, mem_req=0.
REQ-028 Store byte 0x80 at 0x105, then load byte 0x105 with rsign=1 and with rsign=0: expect mem_wstrb=0010 and mem_wdata=0x00008000; then rdata=0xFFFFFF80 and rdata=0x00000080, both hits.
REQ-029 Store to 0x2000 (miss), then load 0x2000: expect one write beat, then a full refill, proving no allocate on store.
REQ-030 Assert rst=0 mid-refill after beat 2, then release and load the same address: expect mem_req=0 at the reset edge and a full 4-beat refill afterwards.
REQ-031 With DCACHE_STATS_EN, run REQ-026 then REQ-027: expect miss_cnt=1, hit_cnt=1.
